// File: rtl/fast_pixel_pos.sv
// Raster-scan pixel sequencer for the FAST datapath: issues SRAM2 reads in raster order
// and the matching SRAM4 writes one cycle later to cover the SRAM read latency.
module fast_pixel_pos #(
  parameter int X_MAX = 5,
  parameter int Y_MAX = 5,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [7:0]    SRAM_in,
  input  logic          start,
  input  logic          new_trans,
  output logic          read_SRAM2,
  output logic [XW-1:0] x_addr,
  output logic [YW-1:0] y_addr,
  output logic          write_SRAM4,
  output logic [XW-1:0] x_addr4,
  output logic [YW-1:0] y_addr4
);

  typedef enum logic [2:0] {IDLE, ARMED, SCAN, FLUSH, DONE} state_t;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_rd;
  logic [XW-1:0] r_xa;
  logic [YW-1:0] r_ya;
  logic          r_wr;
  logic [XW-1:0] r_xa4;
  logic [YW-1:0] r_ya4;

  // SRAM_in feeds SRAM4 externally and plays no part in sequencing.
  logic w_unused;
  assign w_unused = ^SRAM_in;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_rd    <= 1'b0;
      r_xa    <= '0;
      r_ya    <= '0;
      r_wr    <= 1'b0;
      r_xa4   <= '0;
      r_ya4   <= '0;
    end else begin
      // The write stage always advances, even on the edge that re-arms a new transaction.
      r_wr <= r_rd;
      if (r_rd) begin
        r_xa4 <= r_xa;
        r_ya4 <= r_ya;
      end
      r_rd <= 1'b0;
      r_xa <= r_x;
      r_ya <= r_y;
      if (new_trans) begin
        r_state <= ARMED;
        r_x     <= '0;
        r_y     <= '0;
        r_xa    <= '0;
        r_ya    <= '0;
      end else begin
        case (r_state)
          ARMED: begin
            if (start) r_state <= SCAN;
          end
          SCAN: begin
            if (start) begin
              r_rd <= 1'b1;
              if (r_x == XW'(X_MAX - 1)) begin
                r_x <= '0;
                if (r_y == YW'(Y_MAX - 1)) begin
                  r_y     <= '0;
                  r_state <= FLUSH;
                end else begin
                  r_y <= r_y + 1'b1;
                end
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
          FLUSH: r_state <= DONE;
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign read_SRAM2  = r_rd;
  assign x_addr      = r_xa;
  assign y_addr      = r_ya;
  assign write_SRAM4 = r_wr;
  assign x_addr4     = r_xa4;
  assign y_addr4     = r_ya4;

endmodule

// File: tb/tb_fast_pixel_pos.sv
// Directed bench for fast_pixel_pos: full scan, DONE hold, pause, restart and async reset,
// with a small SRAM2 model preloaded so pixel (x,y) = 5y+x.
module tb_fast_pixel_pos;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] SRAM_in;
  logic       start;
  logic       new_trans;
  logic       read_SRAM2;
  logic [2:0] x_addr;
  logic [2:0] y_addr;
  logic       write_SRAM4;
  logic [2:0] x_addr4;
  logic [2:0] y_addr4;

  int assertCount = 0;
  int failCount   = 0;
  bit lastRead    = 1'b0;
  int lastIdx     = 0;

  fast_pixel_pos #(.X_MAX(5), .Y_MAX(5)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .SRAM_in    (SRAM_in),
    .start      (start),
    .new_trans  (new_trans),
    .read_SRAM2 (read_SRAM2),
    .x_addr     (x_addr),
    .y_addr     (y_addr),
    .write_SRAM4(write_SRAM4),
    .x_addr4    (x_addr4),
    .y_addr4    (y_addr4)
  );

  always #5 clk = ~clk;

  // SRAM2 model with one-cycle read latency; contents are 5y+x.
  always @(posedge clk) begin
    if (read_SRAM2 === 1'b1) begin
      if (int'(y_addr) * 5 + int'(x_addr) < 25)
        SRAM_in <= 8'(int'(y_addr) * 5 + int'(x_addr));
      else
        SRAM_in <= 8'hFF;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic nt);
    start     = st;
    new_trans = nt;
  endtask

  // One clock: checks the read strobe/address against idx and the pipelined write of the previous read.
  task automatic expectCycle(input bit expRead, input int idx);
    @(posedge clk);
    #1;
    checkOutput("read_SRAM2", 32'(read_SRAM2), 32'(expRead));
    if (expRead) begin
      checkOutput("x_addr", 32'(x_addr), 32'(idx % 5));
      checkOutput("y_addr", 32'(y_addr), 32'(idx / 5));
    end
    checkOutput("write_SRAM4", 32'(write_SRAM4), 32'(lastRead));
    if (lastRead) begin
      checkOutput("x_addr4", 32'(x_addr4), 32'(lastIdx % 5));
      checkOutput("y_addr4", 32'(y_addr4), 32'(lastIdx / 5));
      checkOutput("SRAM_in", 32'(SRAM_in), 32'(lastIdx));
    end
    lastRead = expRead;
    if (expRead) lastIdx = idx;
  endtask

  initial begin
    n_rst = 1'b1;
    SRAM_in = 8'h00;
    applyStimulus(1'b0, 1'b0);
    #12;
    checkOutput("rst_read", 32'(read_SRAM2), 32'd0);
    checkOutput("rst_write", 32'(write_SRAM4), 32'd0);
    checkOutput("rst_x", 32'(x_addr), 32'd0);
    checkOutput("rst_y", 32'(y_addr), 32'd0);
    checkOutput("rst_x4", 32'(x_addr4), 32'd0);
    checkOutput("rst_y4", 32'(y_addr4), 32'd0);
    n_rst = 1'b0;

    $display("[TB] start ignored in IDLE");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) expectCycle(1'b0, 0);

    $display("[TB] full scan");
    applyStimulus(1'b0, 1'b1);
    expectCycle(1'b0, 0);
    applyStimulus(1'b1, 1'b0);
    expectCycle(1'b0, 0);
    for (int i = 0; i < 25; i++) expectCycle(1'b1, i);
    expectCycle(1'b0, 0);
    expectCycle(1'b0, 0);

    $display("[TB] DONE hold");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'(i % 2), 1'b0);
      expectCycle(1'b0, 0);
    end

    $display("[TB] new_trans beats start, then pause");
    applyStimulus(1'b1, 1'b1);
    expectCycle(1'b0, 0);
    applyStimulus(1'b1, 1'b0);
    expectCycle(1'b0, 0);
    for (int i = 0; i <= 7; i++) expectCycle(1'b1, i);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) expectCycle(1'b0, 0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 8; i <= 13; i++) expectCycle(1'b1, i);

    $display("[TB] restart during scan at (3,2)");
    applyStimulus(1'b1, 1'b1);
    expectCycle(1'b0, 0);
    applyStimulus(1'b0, 1'b0);
    expectCycle(1'b0, 0);
    expectCycle(1'b0, 0);
    applyStimulus(1'b1, 1'b0);
    expectCycle(1'b0, 0);
    for (int i = 0; i < 25; i++) expectCycle(1'b1, i);
    expectCycle(1'b0, 0);
    expectCycle(1'b0, 0);

    $display("[TB] async reset mid-scan");
    applyStimulus(1'b1, 1'b1);
    expectCycle(1'b0, 0);
    applyStimulus(1'b1, 1'b0);
    expectCycle(1'b0, 0);
    for (int i = 0; i < 10; i++) expectCycle(1'b1, i);
    #2;
    n_rst = 1'b1;
    #1;
    checkOutput("mid_rst_read", 32'(read_SRAM2), 32'd0);
    checkOutput("mid_rst_write", 32'(write_SRAM4), 32'd0);
    checkOutput("mid_rst_x", 32'(x_addr), 32'd0);
    checkOutput("mid_rst_y", 32'(y_addr), 32'd0);
    checkOutput("mid_rst_x4", 32'(x_addr4), 32'd0);
    checkOutput("mid_rst_y4", 32'(y_addr4), 32'd0);
    #2;
    n_rst = 1'b0;
    lastRead = 1'b0;
    for (int i = 0; i < 3; i++) expectCycle(1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fast_pixel_pos.md
Name: fast_pixel_pos

Overview:
- Raster-scan pixel-position sequencer for the FAST corner-detector datapath.
- Walks every pixel coordinate of an X_MAX×Y_MAX image and issues read strobes and addresses to the source image SRAM (SRAM2).
- Issues matching delayed write strobes and addresses to the destination SRAM (SRAM4), compensating for the SRAM's one-cycle read latency.
- Write data to SRAM4 is SRAM2's read data, wired externally.

Parameters:
X_MAX  5  image width in pixels; x counter width XW = $clog2(X_MAX)
Y_MAX  5  image height in pixels; y counter width YW = $clog2(Y_MAX)

Ports:
clk          in   1   system clock, all state on rising edge
n_rst        in   1   asynchronous reset, active-high (asserted = 1); name kept per codebase port convention
SRAM_in      in   8   SRAM2 read data, valid the cycle after read_SRAM2; not used for control
start        in   1   level; begin/continue scanning
new_trans    in   1   one-cycle pulse; arm a new image transaction
read_SRAM2   out  1   SRAM2 read enable
x_addr       out  XW  SRAM2 column address
y_addr       out  YW  SRAM2 row address
write_SRAM4  out  1   SRAM4 write enable
x_addr4      out  XW  SRAM4 column address
y_addr4      out  YW  SRAM4 row address

Behaviour:
- Reset, asynchronous while asserted:
  - State IDLE; x/y counters = 0.
  - All outputs 0; write pipeline register cleared.
- States: IDLE, ARMED, SCAN, FLUSH, DONE.
- new_trans = 1 at a rising edge, from any state:
  - Next state ARMED; counters cleared to (0,0).
  - Pending SCAN/FLUSH work is abandoned; the pipeline write for the current cycle still occurs.
- ARMED: start = 1 at a rising edge -> SCAN. start is ignored (including X) in IDLE and DONE.
- SCAN with start = 1:
  - read_SRAM2 = 1; x_addr/y_addr = counters (Moore outputs).
  - Counter step: x increments; at x = X_MAX-1, x wraps to 0 and y increments.
  - At (X_MAX-1, Y_MAX-1) the next state is FLUSH.
- SCAN with start = 0: read_SRAM2 = 0 and counters hold (pause). The scan resumes when start returns to 1.
- Write pipeline, registered:
  - write_SRAM4 = previous cycle's read_SRAM2.
  - x_addr4/y_addr4 = previous cycle's x_addr/y_addr.
  - A write therefore lands exactly one cycle after its read, aligned with SRAM_in.
- FLUSH: read_SRAM2 = 0; the final pipelined write (X_MAX-1, Y_MAX-1) occurs; next state DONE.
- DONE: all strobes 0; holds until new_trans.
- Addresses when not reading: x_addr/y_addr show the counters; x_addr4/y_addr4 hold their last value. Both are don't-care while strobes are low.
- Totals per transaction: exactly X_MAX·Y_MAX reads and X_MAX·Y_MAX writes, each address exactly once, in raster order (x fastest).
- new_trans and start both high in the same cycle: new_trans wins and the state becomes ARMED. Scanning needs start sampled in a later cycle.

Test Plan:
- Reset:
  - Assert n_rst mid-SCAN -> all outputs 0 immediately without waiting for a clock edge.
  - After release, state is IDLE and start = 1 causes no reads.
- Normal scan (X_MAX = Y_MAX = 5):
  - Stimulus: pulse new_trans, then hold start = 1.
  - read_SRAM2 rises the cycle after start is sampled with (0,0), then (1,0), …, (4,0), (0,1), …, (4,4): 25 consecutive cycles.
  - SRAM2 preloaded so pixel (x,y) = 5y+x: SRAM_in sequence is 0..24, one cycle delayed.
- Write alignment: each write_SRAM4 cycle has (x_addr4, y_addr4) equal to the prior cycle's (x_addr, y_addr). 25 writes, last at (4,4) one cycle after the last read; then all strobes 0 in DONE.
- Pause: drop start for 3 cycles after the read of (2,1).
  - No reads during the pause; the write of (2,1) still occurs.
  - Resumes at (3,1); no address is skipped or duplicated.
- Restart: pulse new_trans during SCAN at (3,2).
  - State goes to ARMED and reads stop.
  - Next start restarts the scan at (0,0); 25 full reads follow.
- DONE hold: after completion, toggle start -> no strobes until the next new_trans.
